// File: rtl/sequence_detector_param_fsm.sv
// Serial pattern detector built on a KMP automaton derived from PATTERN at elaboration.
// Supports overlap/non-overlap matching, Moore/Mealy match flag and a saturating match counter.
module sequence_detector_param_fsm #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter bit                     OVERLAP     = 1'b1,
  parameter bit                     MOORE       = 1'b1,
  parameter int                     COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   resetnot,
  input  logic                   w,
  input  logic                   en,
  input  logic                   clear,
  output logic                   z,
  output logic [3:0]             currstate,
  output logic [3:0]             nextstate,
  output logic [COUNT_WIDTH-1:0] match_count,
  output logic [6:0]             HEX0,
  output logic [9:0]             LEDR
);

  typedef logic [3:0]        state_t;
  typedef logic [31:0][3:0]  trans_t;

  localparam state_t                 MATCH_S   = state_t'(PATTERN_LEN);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  // Longest pattern prefix that is a suffix of (prefix of length s) followed by bit b.
  function automatic state_t kmp_step(input int s, input bit b);
    int best;
    bit ok;
    bit tbit;
    best = 0;
    for (int k = 1; k <= PATTERN_LEN; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (s + 1 - k + j < s) tbit = PATTERN[PATTERN_LEN - 1 - (s + 1 - k + j)];
          else                   tbit = b;
          if (PATTERN[PATTERN_LEN - 1 - j] != tbit) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return state_t'(best);
  endfunction

  // Entry {state, bit}; from MATCH without overlap the automaton restarts from state 0.
  function automatic trans_t build_trans();
    trans_t t;
    t = '0;
    for (int s = 0; s <= PATTERN_LEN; s++) begin
      for (int b = 0; b < 2; b++) begin
        if (s == PATTERN_LEN && !OVERLAP) t[2*s + b] = kmp_step(0, bit'(b));
        else                              t[2*s + b] = kmp_step(s, bit'(b));
      end
    end
    return t;
  endfunction

  localparam trans_t TRANS = build_trans();

  state_t                 currstate_q, currstate_d, step_state;
  logic                   z_q, z_d;
  logic                   hit;
  logic [COUNT_WIDTH-1:0] match_count_q, match_count_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    step_state    = TRANS[{currstate_q, w}];
    hit           = en && (step_state == MATCH_S);
    currstate_d   = en ? step_state : currstate_q;
    z_d           = (currstate_d == MATCH_S);
    match_count_d = match_count_q;
    if (clear) begin
      match_count_d = '0;
    end else if (hit && match_count_q != COUNT_MAX) begin
      match_count_d = match_count_q + COUNT_WIDTH'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetnot) begin
      currstate_q   <= '0;
      z_q           <= 1'b0;
      match_count_q <= '0;
    end else begin
      currstate_q   <= currstate_d;
      z_q           <= z_d;
      match_count_q <= match_count_d;
    end
  end

  assign z           = MOORE ? z_q : hit;
  assign currstate   = currstate_q;
  assign nextstate   = currstate_d;
  assign match_count = match_count_q;
  assign LEDR        = {z, 1'b0, 8'(match_count_q)};

  // Active-low segments, bit 0 = a ... bit 6 = g.
  always_comb begin
    HEX0 = 7'b1111111;
    case (currstate_q)
      4'h0: HEX0 = 7'b1000000;
      4'h1: HEX0 = 7'b1111001;
      4'h2: HEX0 = 7'b0100100;
      4'h3: HEX0 = 7'b0110000;
      4'h4: HEX0 = 7'b0011001;
      4'h5: HEX0 = 7'b0010010;
      4'h6: HEX0 = 7'b0000010;
      4'h7: HEX0 = 7'b1111000;
      4'h8: HEX0 = 7'b0000000;
      4'h9: HEX0 = 7'b0010000;
      4'hA: HEX0 = 7'b0001000;
      4'hB: HEX0 = 7'b0000011;
      4'hC: HEX0 = 7'b1000110;
      4'hD: HEX0 = 7'b0100001;
      4'hE: HEX0 = 7'b0000110;
      4'hF: HEX0 = 7'b0001110;
      default: HEX0 = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_sequence_detector_param_fsm.sv
// Bench for sequence_detector_param_fsm: four configurations share one stimulus stream and are
// checked every cycle against a suffix/prefix history model, plus hand-computed expectations.
module tb_sequence_detector_param_fsm;

  localparam int         L   = 4;
  localparam logic [3:0] PAT = 4'b1011;
  // dut 0: overlap Moore, 1: non-overlap Moore, 2: overlap Mealy, 3: overlap Moore 2-bit count
  localparam logic [3:0] OV_CFG    = 4'b1101;
  localparam logic [3:0] MOORE_CFG = 4'b1011;

  logic clock = 1'b0, resetnot = 1'b0, w = 1'b0, en = 1'b0, clear = 1'b0;

  logic [3:0]       z_v;
  logic [3:0][3:0]  cs_v, ns_v;
  logic [3:0][6:0]  hex_v;
  logic [3:0][9:0]  ledr_v;
  logic [3:0][7:0]  cnt_v;
  logic [1:0]       cnt_sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  sequence_detector_param_fsm #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b1), .COUNT_WIDTH(8))
    u_ov (.clock(clock), .resetnot(resetnot), .w(w), .en(en), .clear(clear), .z(z_v[0]),
          .currstate(cs_v[0]), .nextstate(ns_v[0]), .match_count(cnt_v[0]), .HEX0(hex_v[0]), .LEDR(ledr_v[0]));
  sequence_detector_param_fsm #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MOORE(1'b1), .COUNT_WIDTH(8))
    u_nov (.clock(clock), .resetnot(resetnot), .w(w), .en(en), .clear(clear), .z(z_v[1]),
           .currstate(cs_v[1]), .nextstate(ns_v[1]), .match_count(cnt_v[1]), .HEX0(hex_v[1]), .LEDR(ledr_v[1]));
  sequence_detector_param_fsm #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b0), .COUNT_WIDTH(8))
    u_mealy (.clock(clock), .resetnot(resetnot), .w(w), .en(en), .clear(clear), .z(z_v[2]),
             .currstate(cs_v[2]), .nextstate(ns_v[2]), .match_count(cnt_v[2]), .HEX0(hex_v[2]), .LEDR(ledr_v[2]));
  sequence_detector_param_fsm #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b1), .COUNT_WIDTH(2))
    u_sat (.clock(clock), .resetnot(resetnot), .w(w), .en(en), .clear(clear), .z(z_v[3]),
           .currstate(cs_v[3]), .nextstate(ns_v[3]), .match_count(cnt_sat), .HEX0(hex_v[3]), .LEDR(ledr_v[3]));

  assign cnt_v[3] = {6'b0, cnt_sat};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: history of consumed bits ----------------
  logic [15:0] hist   [4];
  int          hlen   [4];
  int          mstate [4];
  int          mcount [4];
  int          cmax   [4] = '{255, 255, 255, 3};
  bit          mvalid = 1'b0;

  // Longest pattern prefix equal to the last bits consumed (newest bit in h[0]).
  function automatic int longest(input logic [15:0] h, input int len);
    int best;
    bit ok;
    best = 0;
    for (int k = 1; k <= L; k++) begin
      if (k <= len) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (h[k-1-j] != PAT[L-1-j]) ok = 1'b0;
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  function automatic int predict(input int i, input logic wb);
    logic [15:0] h;
    int          len;
    h   = hist[i];
    len = hlen[i];
    if (!OV_CFG[i] && mstate[i] == L) len = 0;
    h   = {h[14:0], wb};
    len = (len < 16) ? len + 1 : 16;
    return longest(h, len);
  endfunction

  function automatic logic [6:0] seg(input int s);
    case (s)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      default: return 7'b1111111;
    endcase
  endfunction

  always @(posedge clock) begin
    int nxt;
    for (int i = 0; i < 4; i++) begin
      if (!resetnot) begin
        hist[i] = '0; hlen[i] = 0; mstate[i] = 0; mcount[i] = 0;
      end else if (mvalid) begin
        if (en) begin
          nxt = predict(i, w);
          if (!OV_CFG[i] && mstate[i] == L) hlen[i] = 0;
          hist[i] = {hist[i][14:0], w};
          if (hlen[i] < 16) hlen[i] = hlen[i] + 1;
          mstate[i] = nxt;
          if (nxt == L && mcount[i] < cmax[i]) mcount[i] = mcount[i] + 1;
        end
        if (clear) mcount[i] = 0;
      end
    end
    if (!resetnot) mvalid = 1'b1;
  end

  // Per-cycle comparison of every output of every instance against the model.
  always @(negedge clock) begin
    int   pn, en_next;
    logic ez;
    if (mvalid) begin
      for (int i = 0; i < 4; i++) begin
        pn      = predict(i, w);
        en_next = en ? pn : mstate[i];
        ez      = MOORE_CFG[i] ? (mstate[i] == L) : (en && pn == L);
        check($sformatf("currstate[%0d]", i), 32'(cs_v[i]), 32'(mstate[i]));
        check($sformatf("nextstate[%0d]", i), 32'(ns_v[i]), 32'(en_next));
        check($sformatf("z[%0d]", i), 32'(z_v[i]), 32'(ez));
        check($sformatf("count[%0d]", i), 32'(cnt_v[i]), 32'(mcount[i]));
        check($sformatf("hex0[%0d]", i), 32'(hex_v[i]), 32'(seg(mstate[i])));
        check($sformatf("ledr[%0d]", i), 32'(ledr_v[i]), 32'({ez, 1'b0, 8'(mcount[i])}));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic wb, input logic eb, input logic cb, input logic rb);
    w = wb; en = eb; clear = cb; resetnot = rb;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ov  [7] = '{1, 2, 3, 4, 2, 3, 4};
    int exp_ovz [7] = '{0, 0, 0, 1, 0, 0, 1};
    int exp_nov [7] = '{1, 2, 3, 4, 0, 1, 1};
    int exp_novz[7] = '{0, 0, 0, 1, 0, 0, 0};
    logic [6:0] stream = 7'b1011011;
    int sat_exp [5] = '{1, 2, 3, 3, 3};

    // 1: reset held for two edges with w toggling
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_state", 32'(cs_v[0]), 32'd0);
    check("rst_z", 32'(z_v[0]), 32'd0);
    check("rst_count", 32'(cnt_v[0]), 32'd0);
    check("rst_hex0", 32'(hex_v[0]), 32'(7'b1000000));
    check("rst_ledr", 32'(ledr_v[0]), 32'd0);

    // 2/3: overlap vs non-overlap on 1,0,1,1,0,1,1
    for (int i = 0; i < 7; i++) begin
      step(stream[6-i], 1'b1, 1'b0, 1'b1);
      check($sformatf("ov_state_%0d", i), 32'(cs_v[0]), 32'(exp_ov[i]));
      check($sformatf("ov_z_%0d", i), 32'(z_v[0]), 32'(exp_ovz[i]));
      check($sformatf("ov_led9_%0d", i), 32'(ledr_v[0][9]), 32'(exp_ovz[i]));
      check($sformatf("nov_state_%0d", i), 32'(cs_v[1]), 32'(exp_nov[i]));
      check($sformatf("nov_z_%0d", i), 32'(z_v[1]), 32'(exp_novz[i]));
    end
    check("ov_count", 32'(cnt_v[0]), 32'd2);
    check("ov_ledr", 32'(ledr_v[0]), 32'h202);
    check("nov_count", 32'(cnt_v[1]), 32'd1);

    // 4: Mealy flag is combinational on the final bit and gated by en
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    w = 1'b1; en = 1'b1;
    #1;
    check("mealy_state3", 32'(cs_v[2]), 32'd3);
    check("mealy_z_early", 32'(z_v[2]), 32'd1);
    check("mealy_next4", 32'(ns_v[2]), 32'd4);
    en = 1'b0;
    #1;
    check("mealy_z_en0", 32'(z_v[2]), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("mealy_hold3", 32'(cs_v[2]), 32'd3);

    // 5: enable gating and clear overriding a same-edge increment
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (5) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
    check("en_hold", 32'(cs_v[0]), 32'd2);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("en_match_state", 32'(cs_v[0]), 32'd4);
    check("en_match_count", 32'(cnt_v[0]), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_state", 32'(cs_v[0]), 32'd4);
    check("clr_z", 32'(z_v[0]), 32'd1);
    check("clr_count", 32'(cnt_v[0]), 32'd0);

    // 6: 2-bit counter saturates; reset mid-pattern discards progress
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("sat_count_0", 32'(cnt_sat), 32'(sat_exp[0]));
    for (int m = 1; m < 5; m++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check($sformatf("sat_count_%0d", m), 32'(cnt_sat), 32'(sat_exp[m]));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("midrst_state", 32'(cs_v[3]), 32'd0);
    check("midrst_count", 32'(cnt_sat), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("postrst_state", 32'(cs_v[3]), 32'd1);
    check("postrst_z", 32'(z_v[3]), 32'd0);
    check("postrst_count", 32'(cnt_sat), 32'd0);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
